// File: rtl/pipelined_addsub_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor: per-stage
// control flags, segment sizing, configuration check and the full-adder cell.
package addsub_pkg;

    typedef struct packed {
        logic valid;
        logic carry;
        logic ovf;
        logic zero_acc;
    } stage_flags_t;

    function automatic int seg_width(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic bit cfg_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

    // Returns {carry_out, sum}
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

endpackage

// File: rtl/pipelined_addsub_if.sv
// Operand/result stream bundle for pipelined_addsub (valid/ready both ways).
interface pipelined_addsub_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf, zero
    );
endinterface

// File: rtl/pipelined_addsub_ripple_segment.sv
// Combinational SEG-bit ripple-carry segment; also exposes the carry into
// its MSB so the last segment can derive signed overflow.
module ripple_segment
    import addsub_pkg::*;
#(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] s,
    output logic           cout,
    output logic           cmsb
);
    logic       carry;
    logic       carry_msb;
    logic [1:0] fa;

    // Ripple the carry through SEG full-adder cells
    always_comb begin
        s         = '0;
        carry     = cin;
        carry_msb = cin;
        fa        = 2'b00;
        for (int i = 0; i < SEG; i++) begin
            carry_msb = carry;
            fa        = full_add(a[i], b[i], carry);
            s[i]      = fa[0];
            carry     = fa[1];
        end
    end

    assign cout = carry;
    assign cmsb = carry_msb;
endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined adder/subtractor: STAGES ripple segments separated by registers,
// one global advance signal, last stage register drives the result stream.
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input logic               clk,
    input logic               rst,
    pipelined_addsub_if.slave bus
);
    localparam int SEG = seg_width(WIDTH, STAGES);

    typedef struct packed {
        stage_flags_t     flags;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] sum;
    } payload_t;

    payload_t head;
    payload_t last;
    logic     adv;

    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_check
        $error("pipelined_addsub: need 1 <= STAGES <= WIDTH and WIDTH %% STAGES == 0");
    end

    assign adv          = !last.flags.valid || bus.out_ready;
    assign bus.in_ready = adv;

    // Operand prep: subtraction is A + ~B + 1; a non-accepted slot becomes a bubble
    always_comb begin
        head                = '0;
        head.flags.valid    = bus.in_valid;
        head.flags.carry    = bus.sub ? 1'b1 : bus.cin;
        head.flags.ovf      = 1'b0;
        head.flags.zero_acc = 1'b1;
        head.a              = bus.a;
        head.b              = bus.sub ? ~bus.b : bus.b;
        head.sum            = '0;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        payload_t       cur;
        payload_t       nxt;
        payload_t       q;
        logic [SEG-1:0] seg_s;
        logic           seg_co;
        logic           seg_cm;

        if (k == 0) begin : g_src
            assign cur = head;
        end else begin : g_src
            assign cur = g_stage[k-1].q;
        end

        ripple_segment #(.SEG(SEG)) u_seg (
            .a    (cur.a[k*SEG +: SEG]),
            .b    (cur.b[k*SEG +: SEG]),
            .cin  (cur.flags.carry),
            .s    (seg_s),
            .cout (seg_co),
            .cmsb (seg_cm)
        );

        // Fold this segment's slice result into the travelling payload
        always_comb begin
            nxt                   = cur;
            nxt.sum[k*SEG +: SEG] = seg_s;
            nxt.flags.carry       = seg_co;
            nxt.flags.ovf         = seg_co ^ seg_cm;
            nxt.flags.zero_acc    = cur.flags.zero_acc && (seg_s == '0);
        end

        // Stage register: cleared by reset, otherwise moves only with the whole pipe
        always_ff @(posedge clk) begin
            if (rst) begin
                q <= '0;
            end else if (adv) begin
                q <= nxt;
            end
        end
    end

    assign last = g_stage[STAGES-1].q;

    assign bus.out_valid = last.flags.valid;
    assign bus.s         = last.sum;
    assign bus.cout      = last.flags.carry;
    assign bus.ovf       = last.flags.ovf;
    assign bus.zero      = last.flags.zero_acc;
endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
Parametrised, pipelined adder/subtractor: the next generation of our 32-bit ripple-carry adder. The carry chain is split into STAGES equal ripple segments separated by registers, so the block closes timing at wide WIDTH. Operands move through a valid/ready stream interface with backpressure. The block sits between the operand-fetch and writeback stages of the datapath and reports carry, signed overflow and zero flags.

Parameters:
WIDTH, 32, operand and result width in bits; must be divisible by STAGES
STAGES, 4, number of pipeline segments (1..WIDTH); SEG = WIDTH/STAGES bits per segment

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand beat valid
in_ready  out  1  block can accept a beat this cycle
a  in  WIDTH  operand A (unsigned or two's complement)
b  in  WIDTH  operand B
cin  in  1  carry-in; used only when sub=0
sub  in  1  1 = A-B, 0 = A+B+cin
out_valid  out  1  result beat valid
out_ready  in  1  downstream accepts the result
s  out  WIDTH  sum or difference, modulo 2^WIDTH
cout  out  1  carry out of the MSB (for sub: 1 = no borrow)
ovf  out  1  signed overflow
zero  out  1  s == 0

Behaviour:
- Reset: every stage valid bit clears to 0; out_valid=0, s=0, cout=0, ovf=0, zero=0. In-flight beats are discarded. in_ready=1 in the first cycle after rst deasserts.
- Operand prep: b_eff = sub ? ~b : b; c0 = sub ? 1 : cin.
- Global advance: adv = !out_valid || out_ready. in_ready = adv. A beat is accepted when in_valid && in_ready.
- When adv=1, every stage register loads from its predecessor and stage 0 loads the new beat, or a bubble (valid=0) if none is accepted. When adv=0, all stage registers hold, including out_*.
- Stage k (0..STAGES-1) adds slice [k*SEG +: SEG] of a and b_eff with the carry registered by stage k-1 (c0 for k=0). It registers the slice sum, the carry out, and an accumulated zero flag (previous zero AND slice==0). Unprocessed upper slices of a and b_eff travel unchanged alongside, and completed lower sum slices travel forward.
- Latency: exactly STAGES cycles from acceptance to out_valid with no stall. Throughput: 1 beat/cycle while out_ready=1.
- Final stage: cout = carry out of bit WIDTH-1. ovf = carry into MSB XOR carry out of MSB. zero = accumulated flag. All are registered and valid only with out_valid.
- A stall (out_valid=1, out_ready=0) holds s/cout/ovf/zero stable until the handshake completes. Beats are never lost or duplicated, and order is preserved.
- Simultaneous accept and output on the same cycle is legal and keeps the pipeline full.
- STAGES=1 degenerates to a single registered full-width adder with latency 1.
- rst dominates in_valid and out_ready in the same cycle.

Decomposition:
- Shared package addsub_pkg: a struct for the per-stage payload (valid, partial sum, remaining a/b_eff, carry, zero_acc, sign bits), a localparam function computing SEG, and an elaboration-time check that WIDTH % STAGES == 0.
- One sub-module: ripple_segment (parameter SEG). It is a purely combinational SEG-bit ripple adder built from full-adder cells and outputs the sum, the carry out, and the carry into its MSB. It is instantiated STAGES times inside a generate loop; the registers live in pipelined_addsub.

Test Plan:
- Reset then single add (WIDTH=32, STAGES=4): a=0x0000_0001, b=0x0000_0002, cin=0, sub=0 -> out_valid exactly 4 cycles later, s=0x0000_0003, cout=0, ovf=0, zero=0.
- Carry across every segment boundary: a=0xFFFF_FFFF, b=0x0000_0000, cin=1 -> s=0x0000_0000, cout=1, zero=1, ovf=0.
- Subtract and signed overflow: a=0x8000_0000, b=0x0000_0001, sub=1 -> s=0x7FFF_FFFF, cout=1, ovf=1. Then a=5, b=5, sub=1 -> s=0, zero=1, cout=1.
- Backpressure: stream 8 back-to-back beats (a=i, b=i) with out_ready held low for cycles 5..9 -> in_ready low during the stall, outputs held stable, all 8 results 2*i emerge in order with no loss or duplication.
- Reset mid-operation: accept 3 beats, assert rst for 1 cycle -> out_valid stays 0 with no stale beats. A beat sent after reset returns the correct result with a latency of 4.
- Parameter sweep: WIDTH=8 with STAGES=1,2,8, and WIDTH=64 with STAGES=4, using random operands -> results match a reference model for s/cout/ovf/zero, with latency equal to STAGES.
